multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multi-cycle sequencer for the CPU datapath: register file, ALU, 16-to-32 immediate extender, instruction and data memories.
- Steps each instruction through IF/ID/EXE/MEM/WB states from the 6-bit opcode and ALU flags.
- Drives every datapath enable and mux select, including ExtSel to the immediate extender (0 = zero-extend, 1 = sign-extend).
- Replaces the single-cycle decoder; sits between the instruction register and the datapath.

Parameters:
- (none) — opcode, state and ALUOp encodings are fixed constants; see Decomposition.

Ports:
- CLK  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- opcode  input  6  instruction[31:26] from IR; valid from ID onward
- zero  input  1  ALU result == 0
- PCWre  output  1  PC write enable
- IRWre  output  1  instruction register load
- InsMemRW  output  1  instruction memory read enable
- ExtSel  output  1  immediate extend mode
- ALUSrcB  output  1  0 = rt data, 1 = extended immediate
- ALUOp  output  3  000 add, 001 sub, 011 or, 100 and, 110 signed less-than
- RegWre  output  1  register file write enable
- RegDst  output  1  0 = rt, 1 = rd
- WrRegDSrc  output  1  0 = ALU result, 1 = data memory
- mRD  output  1  data memory read
- mWR  output  1  data memory write
- PCSrc  output  2  00 PC+4, 01 PC+4+(ext<<2), 10 jump target
- state  output  4  current state, for debug

Behaviour:
- Opcodes: add 000000, sub 000001, addi 000010, and 010000, ori 010010, slti 100110, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, halt 111111.
- States: IF 0000, ID 0001, EXE_R 0010, EXE_B 0011, EXE_LS 0100, MEM 0101, WB_R 0110, WB_L 0111, HALT 1000.
- State register: updates on posedge CLK. Reset low forces state = IF asynchronously, and while Reset is low all enables (PCWre, IRWre, RegWre, mRD, mWR, InsMemRW) are 0.
- Outputs are combinational from state and opcode. Outputs not listed for a state are 0.
- Transitions:
  - IF → ID always.
  - ID:
    - j → IF
    - halt → HALT
    - beq/bne → EXE_B
    - lw/sw → EXE_LS
    - add/sub/addi/and/ori/slti → EXE_R
    - undefined opcode → IF (executes as a nop)
  - EXE_R → WB_R → IF.
  - EXE_B → IF.
  - EXE_LS → MEM.
  - MEM: sw → IF; lw → WB_L.
  - WB_L → IF.
  - HALT → HALT until reset.
- IF: InsMemRW = 1, IRWre = 1.
- PCWre = 1 for exactly one cycle per instruction, in the final state:
  - ID for j and undefined opcodes (PCSrc = 10 for j, 00 otherwise)
  - EXE_B (PCSrc = 01 if taken, else 00)
  - MEM for sw
  - WB_R
  - WB_L
- Branch taken: (beq && zero) || (bne && !zero), sampled in EXE_B. Branch ALUOp = 001.
- Latency: j 2 cycles; beq/bne 3; R-type, immediate and sw 4; lw 5.
- ExtSel = 1 for addi, slti, lw, sw, beq, bne; 0 for ori and all others. Held valid ID through the last state.
- ALUSrcB = 1 for addi, ori, slti, lw, sw.
- RegDst = 1 for add, sub, and.
- ALUOp per instruction: add/addi/lw/sw → 000; sub/beq/bne → 001; ori → 011; and → 100; slti → 110.
- MEM: mRD = 1 for lw, mWR = 1 for sw.
- Write-back:
  - WB_R: RegWre = 1, WrRegDSrc = 0.
  - WB_L: RegWre = 1, WrRegDSrc = 1; mRD stays 1.
- HALT: all enables 0; PC frozen.
- Reset mid-instruction: abandons the instruction; no partial writes are issued after the asynchronous assert.

Decomposition:
- Shared constants file: opcode codes, state codes, ALUOp codes, PCSrc codes.
- One natural sub-module, control_decode: purely combinational map (state, opcode, zero) → control outputs.
- The top level holds the state register and next-state logic.

Test Plan:
- Reset low mid-EXE_R, then release → state = 0000, all enables 0 during reset; IRWre = 1 on the first cycle after release.
- addi (000010) → states 0,1,2,6,0; ExtSel = 1, ALUSrcB = 1, RegWre = 1 only in WB_R, PCWre = 1 only in WB_R.
- ori (010010) → ExtSel = 0, ALUOp = 011, 4 cycles.
- lw (110001) → 5 cycles; mRD = 1 in MEM and WB_L; WrRegDSrc = 1 and RegWre = 1 in WB_L.
- sw (110000) → mWR = 1 and PCWre = 1 in MEM; RegWre never asserted.
- beq (110100) with zero = 1 → PCSrc = 01; with zero = 0 → PCSrc = 00; bne with zero = 0 → PCSrc = 01.
- j (111000) → PCWre = 1, PCSrc = 10 in ID; 2 cycles.
- halt (111111) → state 1000 held for 20 cycles with no enables asserted.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// ALU operations, PC source selects and the bundled control word.
package multicycle_control_unit_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_AND  = 6'b010000;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLTI = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_R  = 4'b0010,
        S_EXE_B  = 4'b0011,
        S_EXE_LS = 4'b0100,
        S_MEM    = 4'b0101,
        S_WB_R   = 4'b0110,
        S_WB_L   = 4'b0111,
        S_HALT   = 4'b1000
    } state_t;

    typedef struct packed {
        logic       pc_wre;
        logic       ir_wre;
        logic       ins_mem_rw;
        logic       ext_sel;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic       reg_wre;
        logic       reg_dst;
        logic       wr_reg_d_src;
        logic       m_rd;
        logic       m_wr;
        logic [1:0] pc_src;
    } ctrl_t;

    // Instructions that go through EXE_R / WB_R.
    function automatic logic is_alu_op(input logic [5:0] op);
        return (op == OP_ADD)  || (op == OP_SUB) || (op == OP_ADDI) ||
               (op == OP_AND)  || (op == OP_ORI) || (op == OP_SLTI);
    endfunction

    function automatic logic is_known_op(input logic [5:0] op);
        return is_alu_op(op) || (op == OP_SW) || (op == OP_LW) ||
               (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) ||
               (op == OP_HALT);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface multicycle_control_unit_if;
    logic [5:0] opcode;
    logic       zero;
    logic       PCWre;
    logic       IRWre;
    logic       InsMemRW;
    logic       ExtSel;
    logic       ALUSrcB;
    logic [2:0] ALUOp;
    logic       RegWre;
    logic       RegDst;
    logic       WrRegDSrc;
    logic       mRD;
    logic       mWR;
    logic [1:0] PCSrc;
    logic [3:0] state;

    modport master (
        input  opcode, zero,
        output PCWre, IRWre, InsMemRW, ExtSel, ALUSrcB, ALUOp, RegWre,
               RegDst, WrRegDSrc, mRD, mWR, PCSrc, state
    );

    modport slave (
        output opcode, zero,
        input  PCWre, IRWre, InsMemRW, ExtSel, ALUSrcB, ALUOp, RegWre,
               RegDst, WrRegDSrc, mRD, mWR, PCSrc, state
    );
endinterface

// File: rtl/multicycle_control_unit_decode.sv
// Combinational map from (state, opcode, zero) to the datapath control word.
module control_decode
    import multicycle_control_unit_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    output ctrl_t      ctrl
);

    logic       ext_sel_s;
    logic       alu_src_b_s;
    logic       reg_dst_s;
    logic [2:0] alu_op_s;
    logic       op_phase_s;
    logic       taken_s;
    ctrl_t      ctrl_s;

    assign op_phase_s = (state != S_IF) && (state != S_HALT);
    assign taken_s    = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);

    // Per-opcode operand and ALU selects, held from ID to the last state.
    always_comb begin
        ext_sel_s   = 1'b0;
        alu_src_b_s = 1'b0;
        reg_dst_s   = 1'b0;
        alu_op_s    = ALU_ADD;
        case (opcode)
            OP_ADD:  reg_dst_s = 1'b1;
            OP_SUB:  begin reg_dst_s = 1'b1; alu_op_s = ALU_SUB; end
            OP_AND:  begin reg_dst_s = 1'b1; alu_op_s = ALU_AND; end
            OP_ADDI: begin ext_sel_s = 1'b1; alu_src_b_s = 1'b1; end
            OP_ORI:  begin alu_src_b_s = 1'b1; alu_op_s = ALU_OR; end
            OP_SLTI: begin ext_sel_s = 1'b1; alu_src_b_s = 1'b1; alu_op_s = ALU_SLT; end
            OP_SW,
            OP_LW:   begin ext_sel_s = 1'b1; alu_src_b_s = 1'b1; end
            OP_BEQ,
            OP_BNE:  begin ext_sel_s = 1'b1; alu_op_s = ALU_SUB; end
            default: alu_op_s = ALU_ADD;
        endcase
    end

    // State-dependent enables; PCWre fires once, in each instruction's final state.
    always_comb begin
        ctrl_s           = '0;
        ctrl_s.ext_sel   = op_phase_s & ext_sel_s;
        ctrl_s.alu_src_b = op_phase_s & alu_src_b_s;
        ctrl_s.reg_dst   = op_phase_s & reg_dst_s;
        ctrl_s.alu_op    = op_phase_s ? alu_op_s : ALU_ADD;
        case (state)
            S_IF: begin
                ctrl_s.ir_wre     = 1'b1;
                ctrl_s.ins_mem_rw = 1'b1;
            end
            S_ID: begin
                if (opcode == OP_J) begin
                    ctrl_s.pc_wre = 1'b1;
                    ctrl_s.pc_src = PC_JUMP;
                end else if (!is_known_op(opcode)) begin
                    ctrl_s.pc_wre = 1'b1;
                end else begin
                    ctrl_s.pc_wre = 1'b0;
                end
            end
            S_EXE_B: begin
                ctrl_s.pc_wre = 1'b1;
                ctrl_s.pc_src = taken_s ? PC_BRANCH : PC_SEQ;
            end
            S_MEM: begin
                if (opcode == OP_LW) begin
                    ctrl_s.m_rd = 1'b1;
                end else if (opcode == OP_SW) begin
                    ctrl_s.m_wr   = 1'b1;
                    ctrl_s.pc_wre = 1'b1;
                end else begin
                    ctrl_s.m_rd = 1'b0;
                end
            end
            S_WB_R: begin
                ctrl_s.pc_wre  = 1'b1;
                ctrl_s.reg_wre = 1'b1;
            end
            S_WB_L: begin
                ctrl_s.pc_wre       = 1'b1;
                ctrl_s.reg_wre      = 1'b1;
                ctrl_s.wr_reg_d_src = 1'b1;
                ctrl_s.m_rd         = 1'b1;
            end
            default: ctrl_s.pc_wre = 1'b0;
        endcase
    end

    assign ctrl = ctrl_s;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: state register and next-state logic,
// with enables forced low while Reset is asserted.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
(
    input  logic                          CLK,
    input  logic                          Reset,
    multicycle_control_unit_if.master     bus
);

    state_t state_r;
    ctrl_t  ctrl_s;

    control_decode u_decode (
        .state  (state_r),
        .opcode (bus.opcode),
        .zero   (bus.zero),
        .ctrl   (ctrl_s)
    );

    // Instruction sequencing; HALT is left only through reset.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_r <= S_IF;
        end else begin
            case (state_r)
                S_IF: state_r <= S_ID;
                S_ID: begin
                    if (bus.opcode == OP_J)
                        state_r <= S_IF;
                    else if (bus.opcode == OP_HALT)
                        state_r <= S_HALT;
                    else if ((bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE))
                        state_r <= S_EXE_B;
                    else if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW))
                        state_r <= S_EXE_LS;
                    else if (is_alu_op(bus.opcode))
                        state_r <= S_EXE_R;
                    else
                        state_r <= S_IF;
                end
                S_EXE_R:  state_r <= S_WB_R;
                S_EXE_B:  state_r <= S_IF;
                S_EXE_LS: state_r <= S_MEM;
                S_MEM:    state_r <= (bus.opcode == OP_LW) ? S_WB_L : S_IF;
                S_WB_R:   state_r <= S_IF;
                S_WB_L:   state_r <= S_IF;
                S_HALT:   state_r <= S_HALT;
                default:  state_r <= S_IF;
            endcase
        end
    end

    // Enables are masked by Reset so nothing is written during the async assert.
    assign bus.PCWre     = ctrl_s.pc_wre     & Reset;
    assign bus.IRWre     = ctrl_s.ir_wre     & Reset;
    assign bus.InsMemRW  = ctrl_s.ins_mem_rw & Reset;
    assign bus.RegWre    = ctrl_s.reg_wre    & Reset;
    assign bus.mRD       = ctrl_s.m_rd       & Reset;
    assign bus.mWR       = ctrl_s.m_wr       & Reset;
    assign bus.ExtSel    = ctrl_s.ext_sel;
    assign bus.ALUSrcB   = ctrl_s.alu_src_b;
    assign bus.ALUOp     = ctrl_s.alu_op;
    assign bus.RegDst    = ctrl_s.reg_dst;
    assign bus.WrRegDSrc = ctrl_s.wr_reg_d_src;
    assign bus.PCSrc     = ctrl_s.pc_src;
    assign bus.state     = state_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle state and control word
// vectors with hand-computed expectations.
module tb_multicycle_control_unit;

    logic CLK;
    logic Reset;
    int   n_cmp;
    int   n_bad;

    multicycle_control_unit_if bus ();

    multicycle_control_unit dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string      tag;
        logic [5:0] op;
        logic       z;
        logic [3:0] st;
        logic [14:0] ct;
    } vec_t;

    vec_t vecs[$];

    // Control word: {PCWre,IRWre,InsMemRW,ExtSel,ALUSrcB,ALUOp,RegWre,RegDst,WrRegDSrc,mRD,mWR,PCSrc}
    localparam logic [14:0] C_ZERO  = 15'b0_0_0_0_0_000_0_0_0_0_0_00;
    localparam logic [14:0] C_IF    = 15'b0_1_1_0_0_000_0_0_0_0_0_00;
    localparam logic [14:0] ADDI_D  = 15'b0_0_0_1_1_000_0_0_0_0_0_00;
    localparam logic [14:0] ADDI_W  = 15'b1_0_0_1_1_000_1_0_0_0_0_00;
    localparam logic [14:0] ORI_D   = 15'b0_0_0_0_1_011_0_0_0_0_0_00;
    localparam logic [14:0] ORI_W   = 15'b1_0_0_0_1_011_1_0_0_0_0_00;
    localparam logic [14:0] ADD_D   = 15'b0_0_0_0_0_000_0_1_0_0_0_00;
    localparam logic [14:0] ADD_W   = 15'b1_0_0_0_0_000_1_1_0_0_0_00;
    localparam logic [14:0] SUB_D   = 15'b0_0_0_0_0_001_0_1_0_0_0_00;
    localparam logic [14:0] SUB_W   = 15'b1_0_0_0_0_001_1_1_0_0_0_00;
    localparam logic [14:0] AND_D   = 15'b0_0_0_0_0_100_0_1_0_0_0_00;
    localparam logic [14:0] AND_W   = 15'b1_0_0_0_0_100_1_1_0_0_0_00;
    localparam logic [14:0] SLTI_D  = 15'b0_0_0_1_1_110_0_0_0_0_0_00;
    localparam logic [14:0] SLTI_W  = 15'b1_0_0_1_1_110_1_0_0_0_0_00;
    localparam logic [14:0] LS_D    = 15'b0_0_0_1_1_000_0_0_0_0_0_00;
    localparam logic [14:0] LW_M    = 15'b0_0_0_1_1_000_0_0_0_1_0_00;
    localparam logic [14:0] LW_W    = 15'b1_0_0_1_1_000_1_0_1_1_0_00;
    localparam logic [14:0] SW_M    = 15'b1_0_0_1_1_000_0_0_0_0_1_00;
    localparam logic [14:0] BR_D    = 15'b0_0_0_1_0_001_0_0_0_0_0_00;
    localparam logic [14:0] BR_T    = 15'b1_0_0_1_0_001_0_0_0_0_0_01;
    localparam logic [14:0] BR_N    = 15'b1_0_0_1_0_001_0_0_0_0_0_00;
    localparam logic [14:0] J_D     = 15'b1_0_0_0_0_000_0_0_0_0_0_10;
    localparam logic [14:0] NOP_D   = 15'b1_0_0_0_0_000_0_0_0_0_0_00;

    function automatic logic [14:0] ctrl_obs();
        return {bus.PCWre, bus.IRWre, bus.InsMemRW, bus.ExtSel, bus.ALUSrcB,
                bus.ALUOp, bus.RegWre, bus.RegDst, bus.WrRegDSrc, bus.mRD,
                bus.mWR, bus.PCSrc};
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_v(input string tag, input logic [5:0] op, input logic z,
                         input logic [3:0] st, input logic [14:0] ct);
        vec_t v;
        v.tag = tag; v.op = op; v.z = z; v.st = st; v.ct = ct;
        vecs.push_back(v);
    endtask

    task automatic add_alu(input string tag, input logic [5:0] op,
                           input logic [14:0] d, input logic [14:0] w);
        add_v({tag, "_if"},  op, 1'b0, 4'd0, C_IF);
        add_v({tag, "_id"},  op, 1'b0, 4'd1, d);
        add_v({tag, "_exe"}, op, 1'b0, 4'd2, d);
        add_v({tag, "_wb"},  op, 1'b0, 4'd6, w);
    endtask

    task automatic add_br(input string tag, input logic [5:0] op, input logic z,
                          input logic [14:0] e);
        add_v({tag, "_if"},  op, z, 4'd0, C_IF);
        add_v({tag, "_id"},  op, z, 4'd1, BR_D);
        add_v({tag, "_exe"}, op, z, 4'd3, e);
    endtask

    // Inputs change right after the falling edge, outputs are sampled 1 time unit later.
    task automatic run_vectors();
        while (vecs.size() > 0) begin
            vec_t v;
            v = vecs.pop_front();
            bus.opcode = v.op;
            bus.zero   = v.z;
            #1;
            check_value({v.tag, "_state"}, {28'd0, bus.state}, {28'd0, v.st});
            check_value({v.tag, "_ctrl"},  {17'd0, ctrl_obs()}, {17'd0, v.ct});
            @(negedge CLK);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        Reset = 1'b0;
        bus.opcode = 6'b000000;
        bus.zero   = 1'b0;
        repeat (2) @(negedge CLK);
        check_value("rst_state", {28'd0, bus.state}, 32'd0);
        check_value("rst_ctrl",  {17'd0, ctrl_obs()}, {17'd0, C_ZERO});
        Reset = 1'b1;

        // Start an add and abandon it in EXE_R.
        add_v("pre_if", 6'b000000, 1'b0, 4'd0, C_IF);
        add_v("pre_id", 6'b000000, 1'b0, 4'd1, ADD_D);
        run_vectors();
        #1;
        check_value("mid_exe_state", {28'd0, bus.state}, 32'd2);
        Reset = 1'b0;
        #1;
        check_value("mid_rst_state", {28'd0, bus.state}, 32'd0);
        check_value("mid_rst_ctrl",  {17'd0, ctrl_obs()}, {17'd0, C_ZERO});
        @(negedge CLK);
        check_value("mid_rst_hold_state", {28'd0, bus.state}, 32'd0);
        check_value("mid_rst_hold_ctrl",  {17'd0, ctrl_obs()}, {17'd0, C_ZERO});
        Reset = 1'b1;

        add_alu("addi", 6'b000010, ADDI_D, ADDI_W);
        add_alu("ori",  6'b010010, ORI_D,  ORI_W);
        add_alu("add",  6'b000000, ADD_D,  ADD_W);
        add_alu("sub",  6'b000001, SUB_D,  SUB_W);
        add_alu("and",  6'b010000, AND_D,  AND_W);
        add_alu("slti", 6'b100110, SLTI_D, SLTI_W);

        add_v("lw_if",  6'b110001, 1'b0, 4'd0, C_IF);
        add_v("lw_id",  6'b110001, 1'b0, 4'd1, LS_D);
        add_v("lw_exe", 6'b110001, 1'b0, 4'd4, LS_D);
        add_v("lw_mem", 6'b110001, 1'b0, 4'd5, LW_M);
        add_v("lw_wb",  6'b110001, 1'b0, 4'd7, LW_W);

        add_v("sw_if",  6'b110000, 1'b0, 4'd0, C_IF);
        add_v("sw_id",  6'b110000, 1'b0, 4'd1, LS_D);
        add_v("sw_exe", 6'b110000, 1'b0, 4'd4, LS_D);
        add_v("sw_mem", 6'b110000, 1'b0, 4'd5, SW_M);

        add_br("beq_z1", 6'b110100, 1'b1, BR_T);
        add_br("beq_z0", 6'b110100, 1'b0, BR_N);
        add_br("bne_z0", 6'b110101, 1'b0, BR_T);
        add_br("bne_z1", 6'b110101, 1'b1, BR_N);

        add_v("j_if", 6'b111000, 1'b0, 4'd0, C_IF);
        add_v("j_id", 6'b111000, 1'b0, 4'd1, J_D);
        add_v("nop_if", 6'b001111, 1'b0, 4'd0, C_IF);
        add_v("nop_id", 6'b001111, 1'b0, 4'd1, NOP_D);

        add_v("halt_if", 6'b111111, 1'b0, 4'd0, C_IF);
        add_v("halt_id", 6'b111111, 1'b0, 4'd1, C_ZERO);
        for (int i = 0; i < 20; i++)
            add_v("halt_hold", 6'b111111, 1'b0, 4'd8, C_ZERO);
        add_v("post_halt", 6'b111111, 1'b0, 4'd8, C_ZERO);
        run_vectors();

        Reset = 1'b0;
        #1;
        check_value("halt_rst_state", {28'd0, bus.state}, 32'd0);
        check_value("halt_rst_ctrl",  {17'd0, ctrl_obs()}, {17'd0, C_ZERO});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
